lcd_host_model: RTL and testbench
=================================

Name: lcd_host_model

Overview:
- Synthesizable far end of the LCD controller interface: the image-ROM responder, command initiator and image-buffer write sink in one block.
- Serves 64×8-bit image ROM reads, issues a preloaded command script on cmd/cmd_valid under the busy handshake, and captures all IRB writes into a result RAM with a running checksum.
- Sits opposite the LCD controller in the integration harness; used for FPGA self-test and as the bench driver.

Parameters:
- CMD_DEPTH, 16, command script FIFO depth (power of 2)
- TIMEOUT, 1024, max cycles busy may stay high per command (optional feature only)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- img_wr_en  in  1  preload image ROM write strobe
- img_wr_addr  in  6  preload address
- img_wr_data  in  8  preload pixel
- cmd_wr_en  in  1  push command into script FIFO
- cmd_wr_data  in  3  command code 0..7 (0 = write-out)
- start  in  1  pulse: begin executing script
- IROM_EN  in  1  active-low ROM read enable from controller
- IROM_A  in  6  ROM read address
- IROM_Q  out  8  ROM data, registered
- cmd  out  3  command to controller
- cmd_valid  out  1  single-cycle command strobe
- busy  in  1  controller busy
- done  in  1  controller done flag
- IRB_RW  in  1  0 = write
- IRB_A  in  6  result write address
- IRB_D  in  8  result write data
- res_rd_addr  in  6  result RAM read address
- res_rd_data  out  8  result RAM data, combinational read
- checksum  out  16  modulo-2^16 sum of all captured IRB_D
- wr_count  out  7  IRB write beats captured, saturates at 127
- fifo_full  out  1  script FIFO full
- script_done  out  1  script finished
- timeout  out  1  watchdog fired

Behaviour:
- Clock and reset: one clock domain, clk; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset state:
  - Outputs: IROM_Q=0, cmd=0, cmd_valid=0, checksum=0, wr_count=0, script_done=0, timeout=0, fifo_full=0.
  - FIFO emptied; FSM to IDLE.
  - Image and result RAM contents are NOT cleared.
- Image ROM:
  - img_wr_en writes mem[img_wr_addr].
  - When IROM_EN==0, IROM_Q <= mem[IROM_A] (1-cycle latency); otherwise IROM_Q holds.
  - Simultaneous preload and read of the same address returns the old data.
- Script FIFO:
  - Push is ignored when full.
  - Pointers wrap modulo CMD_DEPTH.
  - fifo_full is asserted when the count equals CMD_DEPTH.
- Command FSM:
  - IDLE: wait for start. A start pulse while not IDLE is ignored.
  - READY: if the FIFO is empty, go to FIN. Else if busy==0, go to ISSUE.
  - ISSUE: drive cmd_valid=1 for exactly one cycle with cmd = FIFO head; pop; go to GUARD.
  - GUARD: one cycle, ignore busy (the controller raises busy the cycle after cmd_valid); go to WAITB.
  - WAITB: on busy==0, go to READY.
  - FIN: script_done=1; hold until reset.
  - cmd_valid is never asserted while busy==1.
  - Pushes during a run are accepted and executed.
- Result sink:
  - Each cycle with IRB_RW==0: res[IRB_A] <= IRB_D; checksum += IRB_D (zero-extended to 16 bits, wraps); wr_count increments, saturating at 127.
  - A repeated address overwrites the RAM and is counted again.
- done is informational only and does not affect the FSM.

Optional Feature:
- Macro: LCD_HOST_TIMEOUT_EN.
- Defined:
  - A counter clears in GUARD and increments each WAITB cycle with busy==1.
  - When the count reaches TIMEOUT: timeout<=1 (sticky), the FIFO is flushed, FSM goes to FIN.
- Undefined: timeout is tied to 0, no counter exists, and WAITB waits forever.

Decomposition:
- Shared package lcd_pkg:
  - Command codes: CMD_WRITE=0, CMD_UP=1, CMD_DOWN=2, CMD_LEFT=3, CMD_RIGHT=4, CMD_AVG=5, CMD_MIRX=6, CMD_MIRY=7.
  - Image size constant (64) and address width (6).
  - FSM state encoding.
- One sub-module: lcd_cmd_fifo (parameterised synchronous FIFO, 3-bit data).

Test Plan:
- ROM read: preload mem[i]=i+8; drive IROM_EN=0, IROM_A=5 → IROM_Q=13 next cycle. With IROM_EN=1 and IROM_A=6 → IROM_Q stays 13.
- Handshake: push {1,4,0}; start; model busy high for 3 cycles after each strobe → three single-cycle cmd_valid pulses carrying 1,4,0, each exactly when busy==0; script_done=1 after the third.
- Busy gating: hold busy=1 after start for 20 cycles → no cmd_valid. Release busy → cmd_valid within 1 cycle.
- Sink: write 64 beats with IRB_A=k, IRB_D=2k → checksum=4032, wr_count=64, res_rd_data at addr 10 = 20.
- FIFO bound: push 17 commands with CMD_DEPTH=16 → fifo_full=1, 17th dropped, exactly 16 strobes issued.
- Timeout (macro defined, TIMEOUT=8): after the first strobe hold busy=1 → timeout=1 after 8 WAITB cycles; script_done=1; remaining commands not issued. Reset mid-run → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared command codes, image geometry and host FSM state encoding
package lcd_pkg;
  localparam int IMG_SIZE = 64;
  localparam int ADDR_W = 6;
  typedef enum logic [2:0] {
    CMD_WRITE = 3'd0,
    CMD_UP    = 3'd1,
    CMD_DOWN  = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4,
    CMD_AVG   = 3'd5,
    CMD_MIRX  = 3'd6,
    CMD_MIRY  = 3'd7
  } cmd_t;
  typedef enum logic [2:0] {IDLE, READY, ISSUE, GUARD, WAITB, FIN} state_t;
endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: synchronous command FIFO, push dropped when full, flush empties it
// ports: clk, reset, push/din in, pop/flush in, dout (head, combinational), empty, full
module lcd_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic push_ok, pop_ok;
  assign empty = cnt == '0;
  assign full = cnt == CW'(DEPTH);
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) if (push_ok) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(push_ok);
      rp <= rp + AW'(pop_ok);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/lcd_host_model.sv
// lcd_host_model: image-ROM responder, command script initiator and IRB write sink
// ports: img_wr_* preload, cmd_wr_* script push, start, IROM_* ROM read, cmd/cmd_valid/busy/done
// handshake, IRB_* result writes, res_rd_* readback, checksum, wr_count, fifo_full, script_done, timeout
// LCD_HOST_TIMEOUT_EN enables the busy watchdog (TIMEOUT cycles per command)
module lcd_host_model
  import lcd_pkg::*;
#(
  parameter int CMD_DEPTH = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              img_wr_en,
  input  logic [ADDR_W-1:0] img_wr_addr,
  input  logic [7:0]        img_wr_data,
  input  logic              cmd_wr_en,
  input  logic [2:0]        cmd_wr_data,
  input  logic              start,
  input  logic              IROM_EN,
  input  logic [ADDR_W-1:0] IROM_A,
  output logic [7:0]        IROM_Q,
  output logic [2:0]        cmd,
  output logic              cmd_valid,
  input  logic              busy,
  input  logic              done,
  input  logic              IRB_RW,
  input  logic [ADDR_W-1:0] IRB_A,
  input  logic [7:0]        IRB_D,
  input  logic [ADDR_W-1:0] res_rd_addr,
  output logic [7:0]        res_rd_data,
  output logic [15:0]       checksum,
  output logic [6:0]        wr_count,
  output logic              fifo_full,
  output logic              script_done,
  output logic              timeout
);
  logic [7:0] img [IMG_SIZE];
  logic [7:0] res [IMG_SIZE];
  state_t state, nxt;
  logic [2:0] head;
  logic empty, pop, fire;
  logic unused;
  assign unused = done | (TIMEOUT == 0);
  lcd_cmd_fifo #(.DEPTH(CMD_DEPTH), .W(3)) u_fifo (
    .clk(clk), .reset(reset), .push(cmd_wr_en), .din(cmd_wr_data), .pop(pop),
    .flush(fire), .dout(head), .empty(empty), .full(fifo_full)
  );
  assign pop = state == ISSUE;
  assign cmd_valid = pop;
  assign cmd = pop ? head : 3'd0;
  assign script_done = state == FIN;
  assign res_rd_data = res[res_rd_addr];
  always_ff @(posedge clk) begin
    if (img_wr_en) img[img_wr_addr] <= img_wr_data;
    if (!IRB_RW) res[IRB_A] <= IRB_D;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      IROM_Q <= '0;
      checksum <= '0;
      wr_count <= '0;
    end else begin
      state <= nxt;
      if (!IROM_EN) IROM_Q <= img[IROM_A];
      if (!IRB_RW) begin
        checksum <= checksum + {8'd0, IRB_D};
        wr_count <= wr_count + 7'(wr_count != 7'd127);
      end
    end
  end
`ifdef LCD_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  assign fire = state == WAITB && busy && tcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
      timeout <= 1'b0;
    end else begin
      tcnt <= state == GUARD ? '0 : (state == WAITB && busy) ? tcnt + TW'(1) : tcnt;
      if (fire) timeout <= 1'b1;
    end
  end
`else
  assign fire = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? READY : IDLE;
      READY:   nxt = empty ? FIN : !busy ? ISSUE : READY;
      ISSUE:   nxt = GUARD;
      GUARD:   nxt = WAITB;
      WAITB:   nxt = fire ? FIN : !busy ? READY : WAITB;
      FIN:     nxt = FIN;
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lcd_host_model.sv
// tb_lcd_host_model: directed scoreboard bench for lcd_host_model
module tb_lcd_host_model;
  logic clk = 0, reset = 1;
  logic img_wr_en = 0, cmd_wr_en = 0, start = 0, IROM_EN = 1, busy = 0, done = 0, IRB_RW = 1;
  logic [5:0] img_wr_addr = 0, IROM_A = 0, IRB_A = 0, res_rd_addr = 0;
  logic [7:0] img_wr_data = 0, IRB_D = 0, IROM_Q, res_rd_data;
  logic [2:0] cmd_wr_data = 0, cmd;
  logic cmd_valid, fifo_full, script_done, timeout;
  logic [15:0] checksum;
  logic [6:0] wr_count;
  int n_cmp = 0, n_bad = 0, n_str = 0, bcnt = 0;
  logic force_busy = 0;
  logic [2:0] expq [$];

  lcd_host_model #(.CMD_DEPTH(16), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .img_wr_en(img_wr_en), .img_wr_addr(img_wr_addr),
    .img_wr_data(img_wr_data), .cmd_wr_en(cmd_wr_en), .cmd_wr_data(cmd_wr_data),
    .start(start), .IROM_EN(IROM_EN), .IROM_A(IROM_A), .IROM_Q(IROM_Q), .cmd(cmd),
    .cmd_valid(cmd_valid), .busy(busy), .done(done), .IRB_RW(IRB_RW), .IRB_A(IRB_A),
    .IRB_D(IRB_D), .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
    .checksum(checksum), .wr_count(wr_count), .fifo_full(fifo_full),
    .script_done(script_done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // controller model: busy rises the cycle after a strobe and stays high 3 cycles
  initial forever begin
    @(negedge clk);
    busy = force_busy || bcnt > 0;
    if (bcnt > 0) bcnt--;
    if (cmd_valid === 1'b1) bcnt = 3;
  end

  // monitor: every strobe is checked against the scoreboard queue
  initial forever begin
    @(posedge clk);
    #1;
    if (cmd_valid === 1'b1) begin
      n_str++;
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got cmd %0d expected none", cmd);
      end else chk("cmd", {13'd0, cmd}, {13'd0, expq.pop_front()});
      chk("busy_at_strobe", {15'd0, busy}, 16'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic push(input logic [2:0] v, input bit expect_it);
    cmd_wr_data = v;
    cmd_wr_en = 1;
    if (expect_it) expq.push_back(v);
    tick();
    cmd_wr_en = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_sd(input int n);
    int k = 0;
    while (!script_done && k < n) begin
      tick();
      k++;
    end
    chk("script_done", {15'd0, script_done}, 16'd1);
  endtask

  task automatic wait_strobe(input int base, input int n);
    int k = 0;
    while (n_str == base && k < n) begin
      tick();
      k++;
    end
    chk("strobe_seen", 16'(n_str - base), 16'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_IROM_Q"}, {8'd0, IROM_Q}, 16'd0);
    chk({tag, "_cmd"}, {13'd0, cmd}, 16'd0);
    chk({tag, "_cmd_valid"}, {15'd0, cmd_valid}, 16'd0);
    chk({tag, "_checksum"}, checksum, 16'd0);
    chk({tag, "_wr_count"}, {9'd0, wr_count}, 16'd0);
    chk({tag, "_script_done"}, {15'd0, script_done}, 16'd0);
    chk({tag, "_timeout"}, {15'd0, timeout}, 16'd0);
    chk({tag, "_fifo_full"}, {15'd0, fifo_full}, 16'd0);
  endtask

  initial begin
    int base;
    tick();
    do_reset();
    chk_reset_outputs("rst");

    for (int i = 0; i < 64; i++) begin
      img_wr_en = 1;
      img_wr_addr = 6'(i);
      img_wr_data = 8'(i + 8);
      tick();
    end
    img_wr_en = 0;
    IROM_EN = 0;
    IROM_A = 5;
    tick();
    chk("rom_read5", {8'd0, IROM_Q}, 16'd13);
    IROM_EN = 1;
    IROM_A = 6;
    tick();
    chk("rom_hold", {8'd0, IROM_Q}, 16'd13);
    IROM_EN = 0;
    IROM_A = 7;
    img_wr_en = 1;
    img_wr_addr = 7;
    img_wr_data = 99;
    tick();
    img_wr_en = 0;
    chk("rom_rw_old", {8'd0, IROM_Q}, 16'd15);
    tick();
    chk("rom_rw_new", {8'd0, IROM_Q}, 16'd99);
    IROM_EN = 1;

    push(1, 1);
    push(4, 1);
    push(0, 1);
    base = n_str;
    pulse_start();
    wait_sd(100);
    chk("hs_strobes", 16'(n_str - base), 16'd3);
    chk("hs_queue_empty", 16'(expq.size()), 16'd0);

    do_reset();
    repeat (4) tick();
    push(2, 1);
    force_busy = 1;
    tick();
    base = n_str;
    pulse_start();
    repeat (20) tick();
    chk("gate_no_strobe", 16'(n_str - base), 16'd0);
    force_busy = 0;
    wait_strobe(base, 3);
    wait_sd(50);

    do_reset();
    for (int k = 0; k < 64; k++) begin
      IRB_RW = 0;
      IRB_A = 6'(k);
      IRB_D = 8'(2 * k);
      tick();
    end
    IRB_RW = 1;
    res_rd_addr = 10;
    #1;
    chk("sink_checksum", checksum, 16'd4032);
    chk("sink_wr_count", {9'd0, wr_count}, 16'd64);
    chk("sink_res10", {8'd0, res_rd_data}, 16'd20);
    IRB_RW = 0;
    IRB_A = 10;
    IRB_D = 5;
    tick();
    IRB_RW = 1;
    #1;
    chk("sink_rep_res10", {8'd0, res_rd_data}, 16'd5);
    chk("sink_rep_checksum", checksum, 16'd4037);
    chk("sink_rep_wr_count", {9'd0, wr_count}, 16'd65);
    IRB_RW = 0;
    IRB_A = 63;
    IRB_D = 0;
    repeat (70) tick();
    IRB_RW = 1;
    chk("sink_saturate", {9'd0, wr_count}, 16'd127);
    chk("sink_sat_checksum", checksum, 16'd4037);

    do_reset();
    for (int i = 0; i < 15; i++) push(3'(i), 1);
    chk("fifo_not_full15", {15'd0, fifo_full}, 16'd0);
    push(3'd7, 1);
    chk("fifo_full16", {15'd0, fifo_full}, 16'd1);
    push(3'd5, 0);
    chk("fifo_full17", {15'd0, fifo_full}, 16'd1);
    base = n_str;
    pulse_start();
    wait_sd(400);
    chk("fifo_strobes", 16'(n_str - base), 16'd16);
    chk("fifo_queue_empty", 16'(expq.size()), 16'd0);

    do_reset();
    repeat (4) tick();
`ifdef LCD_HOST_TIMEOUT_EN
    push(3, 1);
    push(5, 0);
    push(6, 0);
`else
    push(3, 1);
    push(5, 1);
    push(6, 1);
`endif
    base = n_str;
    pulse_start();
    wait_strobe(base, 20);
    force_busy = 1;
`ifdef LCD_HOST_TIMEOUT_EN
    begin
      int k = 0;
      while (!timeout && k < 30) begin
        tick();
        k++;
      end
    end
    chk("to_timeout", {15'd0, timeout}, 16'd1);
    chk("to_script_done", {15'd0, script_done}, 16'd1);
    force_busy = 0;
    repeat (10) tick();
    chk("to_strobes", 16'(n_str - base), 16'd1);
`else
    repeat (40) tick();
    chk("nto_timeout", {15'd0, timeout}, 16'd0);
    chk("nto_not_done", {15'd0, script_done}, 16'd0);
    force_busy = 0;
    wait_sd(100);
    chk("nto_strobes", 16'(n_str - base), 16'd3);
`endif

    do_reset();
    repeat (4) tick();
    IRB_RW = 0;
    IRB_A = 1;
    IRB_D = 9;
    tick();
    IRB_RW = 1;
    IROM_EN = 0;
    IROM_A = 2;
    tick();
    IROM_EN = 1;
    push(1, 1);
    push(2, 0);
    push(3, 0);
    base = n_str;
    pulse_start();
    wait_strobe(base, 20);
    chk("mid_checksum_pre", checksum, 16'd9);
    do_reset();
    chk_reset_outputs("mid");
    repeat (20) tick();
    chk("mid_no_more_strobes", 16'(n_str - base), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end
endmodule
